// File: rtl/localparam_accum.sv
// Windowed accumulator: sums 2**LOG_COUNT samples (or fewer on flush) and
// presents the sum, the sum >> LOG_COUNT and the sample count behind a valid/ready handshake.
module localparam_accum #(
    parameter int unsigned LOG_WIDTH = 3,
    parameter int unsigned LOG_COUNT = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [2**LOG_WIDTH:0]           in_data,
    input  logic                            flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2**LOG_WIDTH+LOG_COUNT:0] out_sum,
    output logic [2**LOG_WIDTH:0]           out_avg,
    output logic [LOG_COUNT:0]              out_count
);

    localparam int unsigned WIDTH     = 2**LOG_WIDTH + 1;
    localparam int unsigned COUNT     = 2**LOG_COUNT;
    localparam int unsigned SUM_WIDTH = WIDTH + LOG_COUNT;
    localparam logic [LOG_COUNT-1:0] CNT_LAST = LOG_COUNT'(COUNT - 1);

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e                 r_state, w_state_next;
    logic [SUM_WIDTH-1:0]   r_acc, w_acc_next;
    logic [LOG_COUNT-1:0]   r_cnt, w_cnt_next;
    logic                   r_out_valid, w_out_valid_next;
    logic [SUM_WIDTH-1:0]   r_out_sum, w_out_sum_next;
    logic [WIDTH-1:0]       r_out_avg, w_out_avg_next;
    logic [LOG_COUNT:0]     r_out_count, w_out_count_next;

    logic                   w_accept;
    logic [SUM_WIDTH-1:0]   w_sum_in;
    logic [LOG_COUNT:0]     w_cnt_ext;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= StAccum;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_avg   <= '0;
            r_out_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_cnt       <= w_cnt_next;
            r_out_valid <= w_out_valid_next;
            r_out_sum   <= w_out_sum_next;
            r_out_avg   <= w_out_avg_next;
            r_out_count <= w_out_count_next;
        end
    end

    assign in_ready  = (r_state == StAccum);
    assign w_accept  = in_valid && in_ready;
    assign w_sum_in  = r_acc + SUM_WIDTH'(in_data);
    assign w_cnt_ext = {1'b0, r_cnt};

    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_cnt_next       = r_cnt;
        w_out_valid_next = r_out_valid;
        w_out_sum_next   = r_out_sum;
        w_out_avg_next   = r_out_avg;
        w_out_count_next = r_out_count;

        unique case (r_state)
            StAccum: begin
                if (w_accept) begin
                    if (flush || (r_cnt == CNT_LAST)) begin
                        w_out_sum_next   = w_sum_in;
                        w_out_avg_next   = w_sum_in[SUM_WIDTH-1:LOG_COUNT];
                        w_out_count_next = w_cnt_ext + (LOG_COUNT+1)'(1);
                        w_out_valid_next = 1'b1;
                        w_acc_next       = '0;
                        w_cnt_next       = '0;
                        w_state_next     = StHold;
                    end else begin
                        w_acc_next = w_sum_in;
                        w_cnt_next = r_cnt + LOG_COUNT'(1);
                    end
                end else if (flush && (r_cnt != '0)) begin
                    // Empty windows are never emitted.
                    w_out_sum_next   = r_acc;
                    w_out_avg_next   = r_acc[SUM_WIDTH-1:LOG_COUNT];
                    w_out_count_next = w_cnt_ext;
                    w_out_valid_next = 1'b1;
                    w_acc_next       = '0;
                    w_cnt_next       = '0;
                    w_state_next     = StHold;
                end
            end
            StHold: begin
                if (r_out_valid && out_ready) begin
                    w_out_valid_next = 1'b0;
                    w_state_next     = StAccum;
                end
            end
            default: begin
                w_state_next     = StAccum;
                w_acc_next       = '0;
                w_cnt_next       = '0;
                w_out_valid_next = 1'b0;
            end
        endcase
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_avg   = r_out_avg;
    assign out_count = r_out_count;

endmodule

// File: tb/tb_localparam_accum.sv
// Bench for localparam_accum: table-driven windows checked through a result scoreboard,
// plus hand-written hold, empty-flush and asynchronous-reset sequences.
module tb_localparam_accum;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  in_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [10:0] out_sum;
    logic [8:0]  out_avg;
    logic [2:0]  out_count;

    localparam_accum #(.LOG_WIDTH(3), .LOG_COUNT(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_avg  (out_avg),
        .out_count(out_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int              n;
        logic [3:0][8:0] s;
        bit              fl_last;
        bit              fl_after;
        int              e_sum;
        int              e_avg;
        int              e_cnt;
    } vec_t;

    typedef struct {
        int sum;
        int avg;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic push(input int s, input int a, input int c);
        exp_t e;
        e.sum = s;
        e.avg = a;
        e.cnt = c;
        sb.push_back(e);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic send(input logic [8:0] d, input logic f);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        flush    = f;
        while (!in_ready && waited < 20) begin
            @(posedge clock);
            #1;
            waited++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic flush_alone();
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(posedge clock);
            #1;
            waited++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    // Result monitor: compares every completed output handshake against the scoreboard.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_sum", int'(out_sum), e.sum);
                chk("out_avg", int'(out_avg), e.avg);
                chk("out_count", int'(out_count), e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    vec_t vecs[6];

    initial begin
        vecs[0] = '{4, {9'd4, 9'd3, 9'd2, 9'd1}, 1'b0, 1'b0, 10, 2, 4};
        vecs[1] = '{4, {9'd511, 9'd511, 9'd511, 9'd511}, 1'b0, 1'b0, 2044, 511, 4};
        vecs[2] = '{2, {9'd0, 9'd0, 9'd200, 9'd100}, 1'b0, 1'b1, 300, 75, 2};
        vecs[3] = '{4, {9'd8, 9'd7, 9'd6, 9'd5}, 1'b1, 1'b0, 26, 6, 4};
        vecs[4] = '{3, {9'd0, 9'd30, 9'd20, 9'd10}, 1'b1, 1'b0, 60, 15, 3};
        vecs[5] = '{1, {9'd0, 9'd0, 9'd0, 9'd7}, 1'b0, 1'b1, 7, 1, 1};

        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_avg", int'(out_avg), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                bit last;
                last = (i == vecs[v].n - 1);
                if (last && (vecs[v].fl_last || vecs[v].n == 4))
                    push(vecs[v].e_sum, vecs[v].e_avg, vecs[v].e_cnt);
                send(vecs[v].s[i], last && vecs[v].fl_last);
            end
            if (vecs[v].fl_after) begin
                push(vecs[v].e_sum, vecs[v].e_avg, vecs[v].e_cnt);
                flush_alone();
            end
            drain();
        end

        // Flush on an empty window must not produce a result.
        flush_alone();
        repeat (3) begin
            @(negedge clock);
            chk("empty_flush_valid", int'(out_valid), 0);
        end
        @(posedge clock);
        #1;

        // Hold a result with out_ready low.
        out_ready = 1'b0;
        push(10, 2, 4);
        send(9'd1, 1'b0);
        send(9'd2, 1'b0);
        send(9'd3, 1'b0);
        send(9'd4, 1'b0);
        repeat (5) begin
            @(negedge clock);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_sum", int'(out_sum), 10);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("release_valid", int'(out_valid), 0);
        chk("release_in_ready", int'(in_ready), 1);
        chk("release_sum_kept", int'(out_sum), 10);

        // Asynchronous reset mid-window discards the partial sum.
        send(9'd9, 1'b0);
        send(9'd9, 1'b0);
        send(9'd9, 1'b0);
        reset = 1'b0;
        #2;
        chk("async_rst_sum", int'(out_sum), 0);
        chk("async_rst_avg", int'(out_avg), 0);
        chk("async_rst_count", int'(out_count), 0);
        chk("async_rst_valid", int'(out_valid), 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        push(4, 1, 4);
        for (int i = 0; i < 4; i++) send(9'd1, 1'b0);
        drain();

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
